// File: rtl/ex_muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and constants for ex_muldiv.
package muldiv_pkg;
   localparam int DEF_DATA_W = 32;
   // LO on divide-by-zero is this bit replicated across DATA_W
   localparam logic DZ_LO_FILL = 1'b1;
   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MADD  = 3'b100,
      OP_MADDU = 3'b101,
      OP_MSUB  = 3'b110,
      OP_MSUBU = 3'b111
   } op_t;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage pipeline <-> multiply/divide unit handshake and result bus.
interface ex_muldiv_if #(parameter int DATA_W = 32);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] opdata1, opdata2, acc_hi, acc_lo;
   logic              annul;
   logic              stall_req, ready, whilo, div_zero;
   logic [DATA_W-1:0] hi, lo;
   modport master (output start, op, opdata1, opdata2, acc_hi, acc_lo, annul,
                   input stall_req, ready, whilo, div_zero, hi, lo);
   modport slave  (input start, op, opdata1, opdata2, acc_hi, acc_lo, annul,
                   output stall_req, ready, whilo, div_zero, hi, lo);
endinterface

// File: rtl/ex_muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract).
module muldiv_div_step #(parameter int DATA_W = 32) (
   input  logic [DATA_W-1:0] rem,
   input  logic              bit_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);
   logic [DATA_W:0] sh, diff;
   assign sh       = {rem, bit_in};
   assign diff     = sh - {1'b0, divisor};
   assign q_bit    = ~diff[DATA_W];
   assign rem_next = q_bit ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle radix-2 multiply / restoring divide unit producing HI/LO.
// Define MULDIV_MACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam int W2 = 2 * DATA_W;
   state_t            state;
   logic [DATA_W-1:0] m, abs1, abs2, quo, rem, hi_q, lo_q, d_rem;
   logic [W2-1:0]     p, mul_next, div_next, mul_res, mul_fin;
   logic [DATA_W:0]   mul_sum;
   logic [CNT_W-1:0]  cnt;
   logic              s1, s2, is_div, skip, neg, neg_rem, wr, ready_q, dz_q, d_q, last;

   assign s1     = ~bus.op[0] & bus.opdata1[DATA_W-1];
   assign s2     = ~bus.op[0] & bus.opdata2[DATA_W-1];
   assign abs1   = s1 ? -bus.opdata1 : bus.opdata1;
   assign abs2   = s2 ? -bus.opdata2 : bus.opdata2;
   assign is_div = bus.op inside {OP_DIV, OP_DIVU};
   assign last   = cnt == CNT_W'(DATA_W - 1);

   // p holds {partial product, remaining multiplier} or {partial remainder, remaining dividend}
   assign mul_sum  = {1'b0, p[W2-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
   assign mul_next = {mul_sum, p[DATA_W-1:1]};
   assign mul_res  = neg ? -mul_next : mul_next;

   muldiv_div_step #(.DATA_W(DATA_W)) u_step (
      .rem     (p[W2-1:DATA_W]),
      .bit_in  (p[DATA_W-1]),
      .divisor (m),
      .rem_next(d_rem),
      .q_bit   (d_q)
   );
   assign div_next = {d_rem, p[DATA_W-2:0], d_q};
   assign quo      = div_next[DATA_W-1:0];
   assign rem      = div_next[W2-1:DATA_W];

`ifdef MULDIV_MACC_EN
   logic [2:0]    op_q;
   logic [W2-1:0] acc;
   assign skip    = 1'b0;
   assign mul_fin = ~op_q[2] ? mul_res : op_q[1] ? acc - mul_res : acc + mul_res;
`else
   assign skip    = bus.op[2];
   assign mul_fin = mul_res;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         m       <= '0;
         p       <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         neg_rem <= 1'b0;
         wr      <= 1'b0;
         ready_q <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULDIV_MACC_EN
         op_q    <= '0;
         acc     <= '0;
`endif
      end else begin
         ready_q <= 1'b0;
         case (state)
            IDLE: if (bus.start && !bus.annul) begin
               cnt     <= '0;
               neg     <= s1 ^ s2;
               neg_rem <= s1;
               m       <= is_div ? abs2 : abs1;
               p       <= {{DATA_W{1'b0}}, is_div ? abs1 : abs2};
               wr      <= ~skip;
`ifdef MULDIV_MACC_EN
               op_q    <= bus.op;
               acc     <= {bus.acc_hi, bus.acc_lo};
`endif
               if (is_div && bus.opdata2 == '0) begin
                  state   <= DONE;
                  ready_q <= 1'b1;
                  dz_q    <= 1'b1;
                  hi_q    <= bus.opdata1;
                  lo_q    <= {DATA_W{DZ_LO_FILL}};
               end else if (skip) begin
                  state   <= DONE;
                  ready_q <= 1'b1;
                  dz_q    <= 1'b0;
               end else
                  state <= is_div ? DIV : MUL;
            end
            MUL, DIV: if (bus.annul)
               state <= IDLE;
            else if (last) begin
               state        <= DONE;
               ready_q      <= 1'b1;
               dz_q         <= 1'b0;
               {hi_q, lo_q} <= state == DIV ? {neg_rem ? -rem : rem, neg ? -quo : quo} : mul_fin;
            end else begin
               p   <= state == DIV ? div_next : mul_next;
               cnt <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall_req = (state == IDLE && bus.start && !bus.annul) || state == MUL || state == DIV;
   assign bus.ready     = ready_q;
   assign bus.whilo     = ready_q & wr & ~bus.annul;
   assign bus.div_zero  = dz_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed + scoreboard bench for ex_muldiv (DATA_W=32); honours MULDIV_MACC_EN.
module tb_ex_muldiv;
   typedef struct {
      logic [31:0] hi, lo;
      logic        dz, wr;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   always #5 clk = ~clk;

   ex_muldiv_if #(.DATA_W(32)) bus ();
   ex_muldiv #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, b, ah, al);
      exp_t        e;
      logic [63:0] prod, acc;
      longint      sa, sb_;
      e.dz = 1'b0; e.wr = 1'b1; e.lat = 33;
      sa   = longint'($signed(a));
      sb_  = longint'($signed(b));
      prod = op[0] ? {32'd0, a} * {32'd0, b} : 64'(sa * sb_);
      acc  = {ah, al};
      if (op[2:1] == 2'b01) begin
         if (b == 0) begin
            e.dz = 1'b1; e.lo = '1; e.hi = a; e.lat = 1;
         end else if (op[0]) begin
            e.lo = a / b; e.hi = a % b;
         end else begin
            e.lo = 32'(sa / sb_); e.hi = 32'(sa % sb_);
         end
      end else if (!op[2])
         {e.hi, e.lo} = prod;
      else begin
`ifdef MULDIV_MACC_EN
         {e.hi, e.lo} = op[1] ? acc - prod : acc + prod;
`else
         e.wr = 1'b0; e.lat = 1; e.hi = last_hi; e.lo = last_lo;
`endif
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after DONE so the next call is back-to-back.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] ah = '0, input logic [31:0] al = '0);
      exp_t e;
      int   n = 0;
      logic got = 1'b0;
      logic st_ok = 1'b1;
      sb.push_back(model(op, a, b, ah, al));
      bus.op = op; bus.opdata1 = a; bus.opdata2 = b; bus.acc_hi = ah; bus.acc_lo = al;
      bus.start = 1'b1;
      #1 chk({tag, "_stall0"}, bus.stall_req, 1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.ready) got = 1'b1;
         else if (bus.stall_req !== 1'b1) st_ok = 1'b0;
      end
      e = sb.pop_front();
      chk({tag, "_ready"}, got, 1);
      chk({tag, "_lat"}, n, e.lat);
      chk({tag, "_stall_busy"}, st_ok, 1);
      chk({tag, "_stall_done"}, bus.stall_req, 0);
      chk({tag, "_hi"}, bus.hi, e.hi);
      chk({tag, "_lo"}, bus.lo, e.lo);
      chk({tag, "_dz"}, bus.div_zero, e.dz);
      chk({tag, "_whilo"}, bus.whilo, e.wr);
      last_hi = e.hi;
      last_lo = e.lo;
      @(negedge clk);
      chk({tag, "_pulse"}, {bus.ready, bus.whilo}, 0);
   endtask

   initial begin
      logic quiet;
      bus.start = 1'b0; bus.op = '0; bus.opdata1 = '0; bus.opdata2 = '0;
      bus.acc_hi = '0; bus.acc_lo = '0; bus.annul = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {bus.ready, bus.whilo, bus.div_zero, bus.stall_req, bus.hi, bus.lo}, 0);
      rst = 1'b1;
      @(negedge clk);

      run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
      run_op("divu", 3'b011, 32'd100, 32'd7);
      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
      run_op("div_zero", 3'b010, 32'h1234_5678, 32'd0);
      run_op("div_pos_neg", 3'b010, 32'd7, 32'hFFFF_FFFE);
      run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000);

      // annul mid-divide: no result, HI/LO untouched, next op completes
      bus.op = 3'b011; bus.opdata1 = 32'd50; bus.opdata2 = 32'd3; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.annul = 1'b1;
      @(posedge clk);
      #1 bus.annul = 1'b0;
      @(negedge clk);
      chk("annul_idle_stall", bus.stall_req, 0);
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready || bus.whilo) quiet = 1'b0;
      end
      chk("annul_no_ready", quiet, 1);
      chk("annul_hold", {bus.hi, bus.lo}, {last_hi, last_lo});
      run_op("after_annul", 3'b011, 32'd1000, 32'd33);

      run_op("maddu", 3'b101, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF);
      run_op("msub", 3'b110, 32'd5, 32'hFFFF_FFFD, 32'h0, 32'd10);
      for (int k = 0; k < 6; k++)
         run_op("rnd", 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);

      // asynchronous reset mid-multiply
      bus.op = 3'b000; bus.opdata1 = 32'd9; bus.opdata2 = 32'd9; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_mid", {bus.ready, bus.whilo, bus.div_zero, bus.stall_req, bus.hi, bus.lo}, 0);
      @(negedge clk);
      rst = 1'b1;
      last_hi = '0;
      last_lo = '0;
      @(negedge clk);
      run_op("after_rst", 3'b001, 32'h0001_0000, 32'h0001_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
